// File: rtl/layer_output_streamer.sv
// Captures one layer's neuron activations, then replays them as a handshaked word stream.
// Define ARGMAX_EN to build a running unsigned argmax over the streamed words.
`ifndef ROM_bitwidth
`define ROM_bitwidth 8
`endif
`ifndef dataWidth
`define dataWidth 16
`endif

module layer_output_streamer #(
    parameter int numNeuron = 30,
    parameter int inWidth   = `ROM_bitwidth,
    parameter int outWidth  = `dataWidth
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numNeuron*inWidth-1:0]   neuron_out,
    input  logic [numNeuron-1:0]           neuron_valid,
    output logic [outWidth-1:0]            out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           layer_done,
    output logic                           overrun,
    output logic [$clog2(numNeuron)-1:0]   argmax_idx,
    output logic                           argmax_valid
);

    localparam int idxW = $clog2(numNeuron);
    localparam logic [idxW-1:0] lastIdx = idxW'(numNeuron - 1);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] STREAM  = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [numNeuron-1:0] got_q, got_d;
    logic [idxW-1:0]      idx_q, idx_d;
    logic                 overrun_q, overrun_d;
    logic [inWidth-1:0]   bufMem_q [numNeuron];
    logic [inWidth-1:0]   bufMem_d [numNeuron];
    logic [inWidth-1:0]   curWord;
    logic                 accept;

    assign curWord = bufMem_q[idx_q];
    assign accept  = (state_q == STREAM) && out_ready;

    // Completion is judged on got plus this cycle's pulses, so streaming starts right after the last capture.
    always_comb begin
        state_d   = state_q;
        got_d     = got_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        bufMem_d  = bufMem_q;
        case (state_q)
            COLLECT: begin
                for (int k = 0; k < numNeuron; k++) begin
                    if (neuron_valid[k]) begin
                        bufMem_d[k] = neuron_out[k*inWidth +: inWidth];
                        got_d[k]    = 1'b1;
                    end
                end
                if (&got_d) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    got_d   = '0;
                end
            end
            STREAM: begin
                if (|neuron_valid) overrun_d = 1'b1;
                if (out_ready) begin
                    if (idx_q == lastIdx) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + idxW'(1);
                    end
                end
            end
            DONE: begin
                if (|neuron_valid) overrun_d = 1'b1;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= COLLECT;
            got_q     <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            bufMem_q  <= '{default: '0};
        end else begin
            state_q   <= state_d;
            got_q     <= got_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            bufMem_q  <= bufMem_d;
        end
    end

    // Outputs decode only registered state, so out_ready never reaches out_valid/out_data combinationally.
    assign out_valid  = (state_q == STREAM);
    assign out_data   = out_valid ? outWidth'(curWord) : '0;
    assign out_last   = out_valid && (idx_q == lastIdx);
    assign layer_done = (state_q == DONE);
    assign overrun    = overrun_q;

`ifdef ARGMAX_EN
    logic [inWidth-1:0] maxVal_q;
    logic [idxW-1:0]    argIdx_q;

    // Strictly-greater update keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            maxVal_q <= '0;
            argIdx_q <= '0;
        end else if (accept) begin
            if (idx_q == '0) begin
                maxVal_q <= curWord;
                argIdx_q <= '0;
            end else if (curWord > maxVal_q) begin
                maxVal_q <= curWord;
                argIdx_q <= idx_q;
            end
        end
    end

    assign argmax_idx   = argIdx_q;
    assign argmax_valid = layer_done;
`else
    assign argmax_idx   = '0;
    assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_output_streamer.sv
// Randomized scoreboard bench for layer_output_streamer (numNeuron=4, inWidth=8, outWidth=16).
module tb_layer_output_streamer;

    localparam int N = 4;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] neuron_out = '0;
    logic [3:0]  neuron_valid = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        layer_done;
    logic        overrun;
    logic [1:0]  argmax_idx;
    logic        argmax_valid;

    int checks = 0;
    int errors = 0;

    exp_t expQ[$];
    int   argQ[$];
    exp_t monHead;
    bit   expectDone = 1'b0;

    logic [7:0] bufModel [N];
    logic [3:0] gotModel = '0;
    bit         collecting = 1'b1;
    bit         overrunExp = 1'b0;
    bit [6:0]   readyPat = 7'b1001101;

    layer_output_streamer #(.numNeuron(N), .inWidth(8), .outWidth(16)) dut (
        .clk(clk), .rst(rst), .neuron_out(neuron_out), .neuron_valid(neuron_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .layer_done(layer_done), .overrun(overrun), .argmax_idx(argmax_idx), .argmax_valid(argmax_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // A complete set of latest values becomes one layer of expected words plus its argmax.
    task automatic pushLayer();
        int best = 0;
        for (int i = 0; i < N; i++) begin
            expQ.push_back('{last: (i == N-1), data: {8'h00, bufModel[i]}});
            if (bufModel[i] > bufModel[best]) best = i;
        end
        argQ.push_back(best);
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] vals);
        bit completed = 1'b0;
        neuron_valid = mask;
        neuron_out   = vals;
        if (collecting) begin
            for (int k = 0; k < N; k++) begin
                if (mask[k]) begin
                    bufModel[k] = vals[k*8 +: 8];
                    gotModel[k] = 1'b1;
                end
            end
            if (&gotModel) begin
                completed  = 1'b1;
                gotModel   = '0;
                collecting = 1'b0;
                pushLayer();
            end
        end else if (|mask) begin
            overrunExp = 1'b1;
        end
        @(posedge clk); #1;
        neuron_valid = '0;
        if (completed) checkOutput("stream_start", out_valid, 1);
        else if (collecting) checkOutput("no_early_stream", out_valid, 0);
        checkOutput("overrun", overrun, overrunExp);
    endtask

    // mode 0: ready always high, 1: fixed 1,0,0,1,1,0,1 pattern, 2: random ready
    task automatic waitDone(input int mode, input int expCycles);
        int cyc = 0;
        int p = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 200) begin
            case (mode)
                0: out_ready = 1'b1;
                1: begin out_ready = readyPat[6 - (p % 7)]; p++; end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            @(posedge clk); #1;
            cyc++;
            if (layer_done) seen = 1'b1;
        end
        checkOutput("layer_done_seen", seen, 1);
        if (expCycles > 0) checkOutput("done_latency", cyc, expCycles);
        checkOutput("all_words_consumed", expQ.size(), 0);
        @(posedge clk); #1;
        collecting = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            expQ.delete();
            argQ.delete();
            expectDone = 1'b0;
        end else begin
            checkOutput("layer_done", layer_done, expectDone);
`ifdef ARGMAX_EN
            checkOutput("argmax_valid", argmax_valid, expectDone);
            if (expectDone && argQ.size() > 0) checkOutput("argmax_idx", argmax_idx, argQ.pop_front());
`else
            checkOutput("argmax_valid_tied", argmax_valid, 0);
            checkOutput("argmax_idx_tied", argmax_idx, 0);
`endif
            expectDone = 1'b0;
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word actual=%0h expected=none at %0t", out_data, $time);
                end else begin
                    monHead = expQ[0];
                    checkOutput("out_data", out_data, monHead.data);
                    checkOutput("out_last", out_last, monHead.last);
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        if (monHead.last) expectDone = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++) bufModel[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_layer_done", layer_done, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_argmax", {argmax_valid, argmax_idx}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] simultaneous capture");
        applyStimulus(4'hF, 32'h40302010);
        waitDone(0, N);

        $display("[TB] staggered capture with overwrite");
        applyStimulus(4'b0100, 32'h00110000);
        applyStimulus(4'b0100, 32'h00990000);
        applyStimulus(4'b0000, 32'h0);
        applyStimulus(4'b0001, 32'h000000A1);
        applyStimulus(4'b0000, 32'h0);
        applyStimulus(4'b0010, 32'h0000B200);
        applyStimulus(4'b1000, 32'hC3000000);
        waitDone(0, N);

        $display("[TB] overrun and backpressure");
        out_ready = 1'b0;
        applyStimulus(4'hF, 32'h0F5A3C77);
        applyStimulus(4'b0010, 32'h0000EE00);
        waitDone(1, -1);
        applyStimulus(4'hF, 32'h10C0C050);
        waitDone(1, -1);
        checkOutput("overrun_sticky", overrun, 1);

        $display("[TB] reset mid-stream");
        applyStimulus(4'hF, 32'h44332211);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_async_valid", out_valid, 0);
        checkOutput("rst_async_data", out_data, 0);
        collecting = 1'b1;
        gotModel   = '0;
        overrunExp = 1'b0;
        for (int k = 0; k < N; k++) bufModel[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_overrun", overrun, 0);
        applyStimulus(4'b0111, 32'h00ABCDEF);
        applyStimulus(4'b0000, 32'h0);
        applyStimulus(4'b0000, 32'h0);
        applyStimulus(4'b1000, 32'h5A000000);
        waitDone(2, -1);

        $display("[TB] randomized layers");
        for (int l = 0; l < 10; l++) begin
            for (int c = 0; collecting; c++) begin
                applyStimulus((c >= 20) ? 4'hF : 4'($urandom_range(0, 15)), $urandom());
            end
            waitDone($urandom_range(0, 2), -1);
        end

        checkOutput("final_queue_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
